// File: rtl/serial_to_word_if.sv
// Bundles the serial-in / word-out signals of serial_to_word; slave = the assembler, master = its environment.
// word_parity exists only when SERIAL_TO_WORD_PARITY_EN is defined.
interface serial_to_word_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overflow;
`ifdef SERIAL_TO_WORD_PARITY_EN
    logic             word_parity;
`endif

    modport slave (
        input  bit_in, bit_valid, frame_start, word_ready,
`ifdef SERIAL_TO_WORD_PARITY_EN
        output word_parity,
`endif
        output word_out, word_valid, bit_count, overflow
    );

    modport master (
        output bit_in, bit_valid, frame_start, word_ready,
`ifdef SERIAL_TO_WORD_PARITY_EN
        input  word_parity,
`endif
        input  word_out, word_valid, bit_count, overflow
    );
endinterface

// File: rtl/serial_to_word.sv
// LSB-first serial-to-parallel assembler with a one-word output buffer; word_valid rises one cycle after the last bit.
// A word completing while the buffer is full and not being consumed is dropped and sets sticky overflow; SERIAL_TO_WORD_PARITY_EN adds word_parity.
module serial_to_word #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    serial_to_word_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] done_word;
    logic             complete;
    logic             load;

    // done_word is the partial word with the incoming bit merged at its position.
    always_comb begin
        done_word = shift_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == cnt_q) begin
                done_word[i] = bus.bit_in;
            end
        end
        complete = bus.bit_valid && !bus.frame_start && (cnt_q == LAST_IDX);

        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (bus.frame_start) begin
            shift_d = '0;
            cnt_d   = '0;
            if (bus.bit_valid) begin
                shift_d[0] = bus.bit_in;
                cnt_d      = CW'(1);
            end
        end else if (bus.bit_valid) begin
            if (complete) begin
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = done_word;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    if (bus.word_ready) begin
                        load = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (bus.word_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        word_d = load ? done_word : word_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SERIAL_TO_WORD_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = load ? ^done_word : parity_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.word_parity = parity_q;
`endif

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.bit_count  = cnt_q;
    assign bus.overflow   = ovf_q;

    // A pending word is never disturbed until the consumer takes it.
    a_word_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == FULL && !bus.word_ready) |=> $stable(word_q));

    a_ovf_sticky: assert property (@(posedge clk) disable iff (!reset_n)
        ovf_q |=> ovf_q);
endmodule

// File: tb/tb_serial_to_word.sv
// Directed bench for serial_to_word at WIDTH=8; inputs change and outputs are sampled 1ns after the rising edge.
module tb_serial_to_word;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    serial_to_word_if #(.WIDTH(WIDTH)) bus ();

    serial_to_word #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bus.bit_in      = b;
        bus.bit_valid   = 1'b1;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], fs && (i == 0));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] w;

        reset_n         = 1'b0;
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.word_ready  = 1'b0;
        idle(2);
        chk("rst_word",  32'(bus.word_out),   32'h0);
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_count", 32'(bus.bit_count),  32'h0);
        chk("rst_ovf",   32'(bus.overflow),   32'h0);
        reset_n = 1'b1;

        // A5 with consumer always ready
        bus.word_ready = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            send_bit(w[i], 1'b0);
            if (i == 2) chk("a5_count3", 32'(bus.bit_count), 32'd3);
        end
        chk("a5_pre_valid", 32'(bus.word_valid), 32'h0);
        chk("a5_pre_count", 32'(bus.bit_count),  32'd7);
        send_bit(w[7], 1'b0);
        chk("a5_word",  32'(bus.word_out),   32'hA5);
        chk("a5_valid", 32'(bus.word_valid), 32'h1);
        chk("a5_count", 32'(bus.bit_count),  32'h0);
        idle(1);
        chk("a5_drop_valid", 32'(bus.word_valid), 32'h0);
        chk("a5_hold_word",  32'(bus.word_out),   32'hA5);

        // 01 then FE with consumer stalled
        bus.word_ready = 1'b0;
        send_word(8'h01, 1'b0);
        chk("ov_first_word", 32'(bus.word_out),   32'h01);
        chk("ov_first_ovf",  32'(bus.overflow),   32'h0);
        send_word(8'hFE, 1'b0);
        chk("ov_word",  32'(bus.word_out),   32'h01);
        chk("ov_valid", 32'(bus.word_valid), 32'h1);
        chk("ov_flag",  32'(bus.overflow),   32'h1);
        bus.word_ready = 1'b1;
        idle(1);
        chk("ov_consumed", 32'(bus.word_valid), 32'h0);
        chk("ov_sticky",   32'(bus.overflow),   32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ovf",   32'(bus.overflow),   32'h0);
        chk("arst_word",  32'(bus.word_out),   32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // partial word then frame_start with 3C
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("fs_partial", 32'(bus.bit_count), 32'd3);
        w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], i == 0);
            if (i == 0) chk("fs_restart", 32'(bus.bit_count), 32'd1);
            if (i == 4) begin
                chk("fs_no_stale_valid", 32'(bus.word_valid), 32'h0);
                chk("fs_count5",         32'(bus.bit_count),  32'd5);
            end
        end
        chk("fs_word",  32'(bus.word_out),   32'h3C);
        chk("fs_valid", 32'(bus.word_valid), 32'h1);
        idle(1);

        // frame_start alone clears the count
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus.frame_start = 1'b1;
        idle(1);
        bus.frame_start = 1'b0;
        chk("fs_only_count", 32'(bus.bit_count), 32'h0);
        send_word(8'hC3, 1'b0);
        chk("fs_only_word", 32'(bus.word_out), 32'hC3);
        idle(1);

        // reset mid-word, bits during reset ignored
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("mid_count5", 32'(bus.bit_count), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.bit_count),  32'h0);
        chk("mid_rst_word",  32'(bus.word_out),   32'h0);
        chk("mid_rst_valid", 32'(bus.word_valid), 32'h0);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_accept", 32'(bus.bit_count), 32'h0);
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        reset_n       = 1'b1;
        send_word(8'hFF, 1'b0);
        chk("post_rst_word", 32'(bus.word_out), 32'hFF);
        chk("post_rst_ovf",  32'(bus.overflow), 32'h0);
        idle(1);

        // 11 pending, consumed on the edge that completes 22
        bus.word_ready = 1'b0;
        send_word(8'h11, 1'b0);
        chk("bb_first", 32'(bus.word_out), 32'h11);
        w = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0);
        chk("bb_stall_word", 32'(bus.word_out), 32'h11);
        bus.word_ready = 1'b1;
        send_bit(w[7], 1'b0);
        chk("bb_word",  32'(bus.word_out),   32'h22);
        chk("bb_valid", 32'(bus.word_valid), 32'h1);
        chk("bb_ovf",   32'(bus.overflow),   32'h0);
        bus.word_ready = 1'b0;
        idle(2);
        chk("bb_hold_word",  32'(bus.word_out),   32'h22);
        chk("bb_hold_valid", 32'(bus.word_valid), 32'h1);

        // ready while empty is harmless
        bus.word_ready = 1'b1;
        idle(3);
        chk("empty_valid", 32'(bus.word_valid), 32'h0);
        chk("empty_word",  32'(bus.word_out),   32'h22);

`ifdef SERIAL_TO_WORD_PARITY_EN
        send_word(8'h07, 1'b0);
        chk("par_07", 32'(bus.word_parity), 32'h1);
        idle(1);
        send_word(8'h03, 1'b0);
        chk("par_03", 32'(bus.word_parity), 32'h0);
        idle(1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_to_word.md
SERIAL_TO_WORD -- requirements
Module: serial_to_word

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial bits per parallel word; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: bit_in  input  1  serial data bit, LSB first, from the upstream bit-serial negator output.
REQ-005 Port: bit_valid  input  1  bit_in is sampled this edge when high.
REQ-006 Port: frame_start  input  1  marks word boundary; discards any partial word.
REQ-007 Port: word_out  output  WIDTH  assembled parallel word, registered.
REQ-008 Port: word_valid  output  1  word_out holds an unconsumed word.
REQ-009 Port: word_ready  input  1  consumer accepts word_out this edge when word_valid is also high.
REQ-010 Port: bit_count  output  $clog2(WIDTH+1)  bits collected in current partial word.
REQ-011 Port: overflow  output  1  sticky flag, completed word dropped because output buffer was full.

Function
REQ-012 Accepted bit (bit_valid=1) is written to shift-register position bit_count; bit_count increments by 1.
REQ-013 frame_start=1 with bit_valid=1: partial word discarded, bit_in stored as bit 0, bit_count becomes 1.
REQ-014 frame_start=1 with bit_valid=0: partial word discarded, bit_count becomes 0.
REQ-015 bit_valid=0 and frame_start=0: shift register and bit_count hold.
REQ-016 On the edge accepting bit WIDTH-1, the word completes: bit_count wraps to 0 on that same edge.
REQ-017 Output buffer state machine: EMPTY (word_valid=0) and FULL (word_valid=1).
REQ-018 EMPTY + completion: word_out loaded with completed word on that edge, go FULL; word_valid visible one cycle after the final bit is presented.
REQ-019 FULL + word_ready=1, no completion: go EMPTY; word_out holds its last value.
REQ-020 FULL + word_ready=1 + completion on same edge: word_out loaded with new word, stay FULL; no overflow.
REQ-021 FULL + word_ready=0 + completion: new word dropped, word_out unchanged, overflow set to 1, stay FULL.
REQ-022 word_out shall not change while word_valid=1 and word_ready=0.
REQ-023 overflow, once set, stays 1 until reset.
REQ-024 word_ready while EMPTY has no effect.

Reset
REQ-025 reset_n low asynchronously forces: word_out=0, word_valid=0, bit_count=0, shift register=0, overflow=0, state EMPTY.
REQ-026 Reset mid-word discards the partial word; first accepted bit after reset_n rises is bit 0.
REQ-027 No bit is accepted on an edge where reset_n is low.

Configuration
REQ-028 Macro SERIAL_TO_WORD_PARITY_EN defined: extra output word_parity (1 bit) = XOR of all bits of the word loaded into word_out, registered with word_out, reset 0, held with word_out.
REQ-029 Macro SERIAL_TO_WORD_PARITY_EN undefined: port word_parity and its logic are absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 Bits 1,0,1,0,0,1,0,1 on consecutive edges, word_ready=1 -> word_out=8'hA5, word_valid high exactly one cycle, bit_count 0 after 8th bit.
REQ-031 Word 8'h01 then 8'hFE back-to-back, word_ready=0 -> word_out stays 8'h01, word_valid=1, overflow=1 after 16th bit.
REQ-032 3 bits of 1, then frame_start with 8'h3C serialised -> single word 8'h3C; no word from the partial bits.
REQ-033 reset_n low after 5 bits of 8'hFF -> all outputs 0; then 8 bits of 8'hFF -> word_out=8'hFF, overflow=0.
REQ-034 8'h11 pending with word_ready=0, word_ready=1 on edge completing 8'h22 -> word_out=8'h22, word_valid stays 1, overflow=0.
REQ-035 With SERIAL_TO_WORD_PARITY_EN: word 8'h07 -> word_parity=1; word 8'h03 -> word_parity=0.
